// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and widths for the stopwatch sequencing controller.
// State encodings match the status value seen by the top level.
package stopwatch_ctrl_pkg;

    localparam int BCD_BIT_WIDTH   = 4;
    localparam int STATE_BIT_WIDTH = 2;

    typedef enum logic [STATE_BIT_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    function automatic logic is_counting(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_updown2.sv
// Two-digit BCD up/down counter with terminal value MAX_HI:MAX_LO.
// Wrap pulse is registered alongside the digits.
module bcd_updown2
    import stopwatch_ctrl_pkg::*;
#(
    parameter int MAX_HI = 5,
    parameter int MAX_LO = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     up_dn,
    input  logic                     clr,
    output logic [BCD_BIT_WIDTH-1:0] hi,
    output logic [BCD_BIT_WIDTH-1:0] lo,
    output logic                     wrap
);

    localparam logic [BCD_BIT_WIDTH-1:0] TOP_HI = BCD_BIT_WIDTH'(MAX_HI);
    localparam logic [BCD_BIT_WIDTH-1:0] TOP_LO = BCD_BIT_WIDTH'(MAX_LO);

    logic at_top;
    logic at_zero;

    assign at_top  = (hi == TOP_HI) && (lo == TOP_LO);
    assign at_zero = (hi == 4'd0) && (lo == 4'd0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hi   <= '0;
            lo   <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                if (!up_dn) begin
                    if (at_top) begin
                        hi   <= '0;
                        lo   <= '0;
                        wrap <= 1'b1;
                    end else if (lo == 4'd9) begin
                        lo <= '0;
                        hi <= hi + 4'd1;
                    end else begin
                        lo <= lo + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        hi   <= TOP_HI;
                        lo   <= TOP_LO;
                        wrap <= 1'b1;
                    end else if (lo == 4'd0) begin
                        lo <= 4'd9;
                        hi <= hi - 4'd1;
                    end else begin
                        lo <= lo - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/lap/clear sequencing over a two-digit BCD counter.
// Display shows the lap snapshot while in LAP, otherwise the live count.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int MAX_HI = 5,
    parameter int MAX_LO = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       pb_start,
    input  logic                       pb_lap,
    input  logic                       pb_clr,
    input  logic                       mode_selection,
    output logic [BCD_BIT_WIDTH-1:0]   cnt_hi,
    output logic [BCD_BIT_WIDTH-1:0]   cnt_lo,
    output logic [BCD_BIT_WIDTH-1:0]   disp_hi,
    output logic [BCD_BIT_WIDTH-1:0]   disp_lo,
    output logic [STATE_BIT_WIDTH-1:0] state,
    output logic                       running,
    output logic                       lap_active,
    output logic                       wrap
);

    sw_state_t                st_q;
    sw_state_t                st_nxt;
    logic                     take_snap;
    logic                     cnt_en;
    logic [BCD_BIT_WIDTH-1:0] snap_hi;
    logic [BCD_BIT_WIDTH-1:0] snap_lo;

    // Counting follows the state before this cycle's transition.
    assign cnt_en = tick && is_counting(st_q) && !pb_clr;

    bcd_updown2 #(
        .MAX_HI (MAX_HI),
        .MAX_LO (MAX_LO)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .up_dn (mode_selection),
        .clr   (pb_clr),
        .hi    (cnt_hi),
        .lo    (cnt_lo),
        .wrap  (wrap)
    );

    always_comb begin
        st_nxt    = st_q;
        take_snap = 1'b0;
        if (pb_clr) begin
            st_nxt = ST_IDLE;
        end else if (pb_start) begin
            case (st_q)
                ST_IDLE:  st_nxt = ST_RUN;
                ST_RUN:   st_nxt = ST_PAUSE;
                ST_PAUSE: st_nxt = ST_RUN;
                ST_LAP:   st_nxt = ST_PAUSE;
                default:  st_nxt = ST_IDLE;
            endcase
        end else if (pb_lap) begin
            if (st_q == ST_RUN) begin
                st_nxt    = ST_LAP;
                take_snap = 1'b1;
            end else if (st_q == ST_LAP) begin
                st_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            snap_hi    <= '0;
            snap_lo    <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            st_q       <= st_nxt;
            running    <= is_counting(st_nxt);
            lap_active <= (st_nxt == ST_LAP);
            if (pb_clr) begin
                snap_hi <= '0;
                snap_lo <= '0;
            end else if (take_snap) begin
                snap_hi <= cnt_hi;
                snap_lo <= cnt_lo;
            end
        end
    end

    assign state   = st_q;
    assign disp_hi = lap_active ? snap_hi : cnt_hi;
    assign disp_lo = lap_active ? snap_lo : cnt_lo;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: a decimal model queues expected outputs per cycle,
// compared against the DUT just after each rising edge.
module tb_stopwatch_ctrl;

    localparam int MH  = 5;
    localparam int ML  = 9;
    localparam int TOP = MH * 10 + ML;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       pb_start = 1'b0;
    logic       pb_lap = 1'b0;
    logic       pb_clr = 1'b0;
    logic       mode_selection = 1'b0;
    logic [3:0] cnt_hi, cnt_lo, disp_hi, disp_lo;
    logic [1:0] state;
    logic       running, lap_active, wrap;

    stopwatch_ctrl #(.MAX_HI(MH), .MAX_LO(ML)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .pb_start       (pb_start),
        .pb_lap         (pb_lap),
        .pb_clr         (pb_clr),
        .mode_selection (mode_selection),
        .cnt_hi         (cnt_hi),
        .cnt_lo         (cnt_lo),
        .disp_hi        (disp_hi),
        .disp_lo        (disp_lo),
        .state          (state),
        .running        (running),
        .lap_active     (lap_active),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [7:0] cnt;
        logic [7:0] disp;
        logic       run;
        logic       lap;
        logic       wrp;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // model state: 0 idle, 1 run, 2 pause, 3 lap
    int m_st   = 0;
    int m_v    = 0;
    int m_snap = 0;
    int m_wrap = 0;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] h, l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic model(input logic r, s, l, c, t, md);
        int v0;
        v0 = m_v;
        m_wrap = 0;
        if (r) begin
            m_st = 0; m_v = 0; m_snap = 0;
        end else if (c) begin
            m_st = 0; m_v = 0; m_snap = 0;
        end else begin
            if (t && (m_st == 1 || m_st == 3)) begin
                if (!md) begin
                    if (v0 == TOP) begin m_v = 0; m_wrap = 1; end
                    else m_v = v0 + 1;
                end else begin
                    if (v0 == 0) begin m_v = TOP; m_wrap = 1; end
                    else m_v = v0 - 1;
                end
            end
            if (s) begin
                m_st = (m_st == 0 || m_st == 2) ? 1 : 2;
            end else if (l) begin
                if (m_st == 1) begin m_st = 3; m_snap = v0; end
                else if (m_st == 3) m_st = 1;
            end
        end
    endtask

    task automatic step(input logic r, s, l, c, t, md);
        exp_t e, g;
        @(negedge clk);
        rst = r; pb_start = s; pb_lap = l; pb_clr = c;
        tick = t; mode_selection = md;
        model(r, s, l, c, t, md);
        e.st   = 2'(m_st);
        e.cnt  = bcd(m_v);
        e.disp = bcd(m_st == 3 ? m_snap : m_v);
        e.run  = (m_st == 1 || m_st == 3);
        e.lap  = (m_st == 3);
        e.wrp  = m_wrap[0];
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("state", {6'd0, state}, {6'd0, g.st});
        check("cnt", {cnt_hi, cnt_lo}, g.cnt);
        check("disp", {disp_hi, disp_lo}, g.disp);
        check("running", {7'd0, running}, {7'd0, g.run});
        check("lap_active", {7'd0, lap_active}, {7'd0, g.lap});
        check("wrap", {7'd0, wrap}, {7'd0, g.wrp});
        rst = 0; pb_start = 0; pb_lap = 0; pb_clr = 0; tick = 0;
    endtask

    task automatic ticks(input int n, input logic md);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, md);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_cnt", {cnt_hi, cnt_lo}, 8'h00);
        check("rst_state", {6'd0, state}, 8'h00);
        step(0, 1, 0, 0, 0, 0);
        ticks(3, 0);
        check("run_cnt03", {cnt_hi, cnt_lo}, 8'h03);
        check("run_state", {6'd0, state}, 8'h01);
        ticks(55, 0);
        check("cnt58", {cnt_hi, cnt_lo}, 8'h58);
        ticks(1, 0);
        check("cnt59", {cnt_hi, cnt_lo}, 8'h59);
        ticks(1, 0);
        check("wrap_up", {7'd0, wrap}, 8'h01);
        check("cnt00", {cnt_hi, cnt_lo}, 8'h00);
        step(0, 0, 0, 0, 0, 0);
        check("wrap_one", {7'd0, wrap}, 8'h00);
        ticks(1, 1);
        check("wrap_dn", {7'd0, wrap}, 8'h01);
        check("dn59", {cnt_hi, cnt_lo}, 8'h59);
        ticks(47, 1);
        check("cnt12", {cnt_hi, cnt_lo}, 8'h12);
        step(0, 0, 1, 0, 0, 0);
        ticks(5, 0);
        check("lap_disp", {disp_hi, disp_lo}, 8'h12);
        check("lap_cnt", {cnt_hi, cnt_lo}, 8'h17);
        step(0, 0, 1, 0, 0, 0);
        check("unlap_disp", {disp_hi, disp_lo}, 8'h17);
        ticks(10, 1);
        step(0, 1, 0, 0, 1, 0);
        check("pause_cnt", {cnt_hi, cnt_lo}, 8'h08);
        check("pause_st", {6'd0, state}, 8'h02);
        ticks(3, 0);
        step(0, 1, 0, 0, 1, 0);
        check("resume_cnt", {cnt_hi, cnt_lo}, 8'h08);
        ticks(22, 0);
        check("cnt30", {cnt_hi, cnt_lo}, 8'h30);
        step(0, 1, 1, 1, 1, 0);
        check("clr_st", {6'd0, state}, 8'h00);
        check("clr_cnt", {cnt_hi, cnt_lo}, 8'h00);
        step(0, 1, 0, 0, 0, 0);
        ticks(5, 0);
        ticks(1, 0);
        check("mode_up", {cnt_hi, cnt_lo}, 8'h06);
        ticks(2, 1);
        check("mode_dn", {cnt_hi, cnt_lo}, 8'h04);
        step(0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        check("rst_mid", {cnt_hi, cnt_lo}, 8'h00);
        check("rst_lap", {7'd0, lap_active}, 8'h00);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
